// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the TX frame scheduler: packet layout, framer
// overhead and the scheduler state encoding.
package tx_pkg;

    localparam int PKT_W     = 136;
    localparam int DEST_MSB  = 135;
    localparam int DEST_LSB  = 132;
    localparam int LEN_MSB   = 131;
    localparam int LEN_LSB   = 128;
    localparam int FRAME_OVH = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_XMIT,
        S_GAP
    } sched_state_t;

    // Nominal number of framer busy cycles for a given length code.
    function automatic int frame_cycles(input logic [3:0] len);
        return FRAME_OVH + (int'(len) + 1) * 8;
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Requester-side and framer-side handshake bundle of the TX frame scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface tx_frame_scheduler_if #(
    parameter int N     = 4,
    parameter int PKT_W = tx_pkg::PKT_W
);

    logic [N-1:0]       req;
    logic [N*PKT_W-1:0] req_packet;
    logic [N-1:0]       done;
    logic [N-1:0]       err;
    logic               tx_start;
    logic [PKT_W-1:0]   tx_packet;
    logic               tx_busy;

    modport master (
        input  req, req_packet, tx_busy,
        output done, err, tx_start, tx_packet
    );

    modport slave (
        output req, req_packet, tx_busy,
        input  done, err, tx_start, tx_packet
    );

endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request at or above rr_ptr,
// wrapping to the bottom when nothing above it is pending.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    // Second pass only matters when nothing at or above rr_ptr was requesting.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (IW'(i) >= rr_ptr)) begin
                valid     = 1'b1;
                grant_idx = IW'(i);
                grant[i]  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                valid     = 1'b1;
                grant_idx = IW'(i);
                grant[i]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one serial TX framer among N requesters:
// grant, start pulse, busy tracking, start timeout and inter-frame gap.
module tx_frame_scheduler #(
    parameter  int N        = 4,
    parameter  int PKT_W    = tx_pkg::PKT_W,
    parameter  int IFG      = 12,
    parameter  int START_TO = 4,
    localparam int IW       = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tx_frame_scheduler_if.master bus,
    output logic [IW-1:0]        owner,
    output logic                 sched_busy,
    output logic [15:0]          frame_cnt
);

    import tx_pkg::*;

    localparam sched_state_t END_STATE = (IFG == 0) ? S_IDLE : S_GAP;

    sched_state_t     state, next_state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner_q;
    logic [PKT_W-1:0] tx_packet_q;
    logic [15:0]      to_cnt;
    logic [15:0]      gap_cnt;
    logic [15:0]      frame_cnt_q;

    logic [N-1:0]     arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_valid;
    logic [PKT_W-1:0] win_packet;

    rr_arbiter #(.N(N)) u_arb (
        .req       (bus.req),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    always_comb begin
        win_packet = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_grant[i]) win_packet = win_packet | bus.req_packet[i*PKT_W +: PKT_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // A timeout and a completed frame both end in the gap (or idle when IFG is 0).
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (arb_valid) next_state = S_START;
            S_START: next_state = S_WAIT;
            S_WAIT: begin
                if (bus.tx_busy)        next_state = S_XMIT;
                else if (to_cnt <= 16'd1) next_state = END_STATE;
            end
            S_XMIT:  if (!bus.tx_busy) next_state = END_STATE;
            S_GAP:   if (gap_cnt <= 16'd1) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_start = (state == S_START);
        bus.done     = '0;
        bus.err      = '0;
        if (state == S_XMIT && !bus.tx_busy) bus.done[owner_q] = 1'b1;
        if (state == S_WAIT && !bus.tx_busy && to_cnt <= 16'd1) bus.err[owner_q] = 1'b1;
        sched_busy   = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            owner_q     <= '0;
            tx_packet_q <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (state == S_IDLE && arb_valid) begin
                tx_packet_q <= win_packet;
                owner_q     <= arb_idx;
                rr_ptr      <= (arb_idx == IW'(N - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (state == S_START) to_cnt <= 16'(START_TO);
            else if (state == S_WAIT && !bus.tx_busy) to_cnt <= to_cnt - 16'd1;
            if (next_state == S_GAP && state != S_GAP) gap_cnt <= 16'(IFG);
            else if (state == S_GAP) gap_cnt <= gap_cnt - 16'd1;
            if (state == S_XMIT && !bus.tx_busy && frame_cnt_q != 16'hFFFF)
                frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.tx_packet = tx_packet_q;
    assign owner         = owner_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: framer model, grant/completion scoreboard,
// table-driven arbitration vectors and hand-written multi-cycle sequences.
module tb_tx_frame_scheduler;

    import tx_pkg::*;

    localparam int N        = 4;
    localparam int IFG      = 12;
    localparam int START_TO = 4;

    typedef struct {
        logic [1:0]       owner;
        logic [PKT_W-1:0] pkt;
        bit               timeout;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  len;
        bit          mute;
        logic [7:0]  order;
        int          n_frames;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  owner;
    logic        sched_busy;
    logic [15:0] frame_cnt;

    int   compared = 0;
    int   mismatched = 0;
    int   cycle = 0;
    int   start_cycle = 0;
    int   last_end_cycle = -1;
    bit   framer_mute = 1'b0;
    exp_t grant_q[$];
    exp_t active_q[$];
    vec_t vecs[7];

    tx_frame_scheduler_if #(.N(N), .PKT_W(PKT_W)) bus();

    tx_frame_scheduler #(
        .N(N), .PKT_W(PKT_W), .IFG(IFG), .START_TO(START_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .owner      (owner),
        .sched_busy (sched_busy),
        .frame_cnt  (frame_cnt)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [PKT_W-1:0] actual,
                               input logic [PKT_W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [PKT_W-1:0] makePkt(input int idx, input logic [3:0] len);
        return {4'(idx), len, 32'hDEAD0000 | 32'(idx), 32'hC0DE0000 | 32'(len),
                32'h5A5A5A5A ^ 32'(idx * 7), 32'h12345678};
    endfunction

    task automatic pushExp(input int idx, input logic [3:0] len, input bit timeout);
        exp_t e;
        e.owner   = 2'(idx);
        e.pkt     = makePkt(idx, len);
        e.timeout = timeout;
        grant_q.push_back(e);
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < N; i++) bus.req_packet[i*PKT_W +: PKT_W] = makePkt(i, v.len);
        framer_mute = v.mute;
        for (int j = 0; j < v.n_frames; j++) pushExp(int'(v.order[2*j +: 2]), v.len, v.mute);
        bus.req = v.req;
    endtask

    task automatic waitIdle(input string name, input int budget);
        bit reached = 1'b0;
        for (int c = 0; c < budget && !reached; c++) begin
            @(negedge clk);
            if (bus.req == '0 && !sched_busy && !bus.tx_busy) reached = 1'b1;
        end
        checkOutput(name, PKT_W'(reached), PKT_W'(1));
    endtask

    // Framer: samples tx_start, raises busy one cycle later for the nominal frame length.
    initial begin
        int busy_len;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_start && !framer_mute) begin
                busy_len = frame_cycles(bus.tx_packet[LEN_MSB:LEN_LSB]);
                @(posedge clk);
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor; the requester model drops req on its done/err.
    initial begin
        exp_t        e;
        bit          ok;
        logic [3:0]  exp_done, exp_err;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.tx_start) begin
                    if (last_end_cycle >= 0)
                        checkOutput("ifg_gap", PKT_W'(cycle - last_end_cycle >= IFG + 2), PKT_W'(1));
                    ok = (grant_q.size() != 0);
                    checkOutput("grant_expected", PKT_W'(ok), PKT_W'(1));
                    if (ok) begin
                        e = grant_q.pop_front();
                        checkOutput("grant_owner", PKT_W'(owner), PKT_W'(e.owner));
                        checkOutput("grant_packet", bus.tx_packet, e.pkt);
                        active_q.push_back(e);
                        start_cycle = cycle;
                    end
                end
                if ((bus.done | bus.err) != '0) begin
                    ok = (active_q.size() != 0);
                    checkOutput("completion_expected", PKT_W'(ok), PKT_W'(1));
                    if (ok) begin
                        e = active_q.pop_front();
                        exp_done = e.timeout ? 4'b0000 : (4'b0001 << e.owner);
                        exp_err  = e.timeout ? (4'b0001 << e.owner) : 4'b0000;
                        checkOutput("done_vector", PKT_W'(bus.done), PKT_W'(exp_done));
                        checkOutput("err_vector", PKT_W'(bus.err), PKT_W'(exp_err));
                        if (e.timeout)
                            checkOutput("err_latency", PKT_W'(cycle - start_cycle), PKT_W'(START_TO));
                        else
                            checkOutput("done_latency", PKT_W'(cycle - start_cycle),
                                        PKT_W'(frame_cycles(e.pkt[LEN_MSB:LEN_LSB]) + 2));
                    end
                    bus.req = bus.req & ~(bus.done | bus.err);
                    last_end_cycle = cycle;
                end
            end
        end
    end

    initial begin
        bit seen;
        int req_cycle, s_cycle, d_cycle;

        // req, len, mute, grant order (2 bits each, first grant in LSBs), frames, frame_cnt after
        vecs[0] = '{4'b1111, 4'd0,  1'b0, 8'hE4, 4, 16'd4};
        vecs[1] = '{4'b0001, 4'd1,  1'b0, 8'h00, 1, 16'd5};
        vecs[2] = '{4'b1000, 4'd2,  1'b0, 8'h03, 1, 16'd6};
        vecs[3] = '{4'b1001, 4'd0,  1'b0, 8'h0C, 2, 16'd8};
        vecs[4] = '{4'b0110, 4'd0,  1'b1, 8'h09, 2, 16'd8};
        vecs[5] = '{4'b0101, 4'd15, 1'b0, 8'h08, 2, 16'd10};
        vecs[6] = '{4'b1010, 4'd3,  1'b0, 8'h07, 2, 16'd12};

        bus.req = '0;
        bus.req_packet = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_start", PKT_W'(bus.tx_start), '0);
        checkOutput("rst_done", PKT_W'(bus.done), '0);
        checkOutput("rst_err", PKT_W'(bus.err), '0);
        checkOutput("rst_owner", PKT_W'(owner), '0);
        checkOutput("rst_sched_busy", PKT_W'(sched_busy), '0);
        checkOutput("rst_frame_cnt", PKT_W'(frame_cnt), '0);
        checkOutput("rst_tx_packet", bus.tx_packet, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k]);
            waitIdle($sformatf("vec%0d_idle", k), 3000);
            checkOutput($sformatf("vec%0d_frame_cnt", k), PKT_W'(frame_cnt), PKT_W'(vecs[k].exp_cnt));
        end
        framer_mute = 1'b0;

        // Single request (rr_ptr now 2): one-cycle grant, 72-cycle frame, gap timing.
        bus.req_packet[2*PKT_W +: PKT_W] = makePkt(2, 4'd3);
        pushExp(2, 4'd3, 1'b0);
        req_cycle = cycle;
        bus.req = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.tx_start) seen = 1'b1;
        end
        s_cycle = cycle;
        checkOutput("single_start_seen", PKT_W'(seen), PKT_W'(1));
        checkOutput("single_start_latency", PKT_W'(s_cycle - req_cycle), PKT_W'(1));
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.done != '0) seen = 1'b1;
        end
        d_cycle = cycle;
        checkOutput("single_done_seen", PKT_W'(seen), PKT_W'(1));
        checkOutput("single_done_latency", PKT_W'(d_cycle - s_cycle), PKT_W'(74));
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (!sched_busy) seen = 1'b1;
        end
        checkOutput("single_idle_seen", PKT_W'(seen), PKT_W'(1));
        checkOutput("single_gap_len", PKT_W'(cycle - d_cycle), PKT_W'(IFG + 1));
        checkOutput("single_frame_cnt", PKT_W'(frame_cnt), PKT_W'(13));

        // Requester 1 drops req mid-frame; done must still arrive.
        bus.req_packet[1*PKT_W +: PKT_W] = makePkt(1, 4'd0);
        pushExp(1, 4'd0, 1'b0);
        bus.req = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.tx_busy) seen = 1'b1;
        end
        checkOutput("drop_busy_seen", PKT_W'(seen), PKT_W'(1));
        repeat (3) @(negedge clk);
        bus.req[1] = 1'b0;
        waitIdle("drop_idle", 200);
        checkOutput("drop_frame_cnt", PKT_W'(frame_cnt), PKT_W'(14));

        // Reset in the middle of requester 2's frame (leaves rr_ptr at 3 beforehand).
        bus.req_packet[2*PKT_W +: PKT_W] = makePkt(2, 4'd2);
        pushExp(2, 4'd2, 1'b0);
        bus.req = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.tx_busy) seen = 1'b1;
        end
        checkOutput("rstmid_busy_seen", PKT_W'(seen), PKT_W'(1));
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_sched_busy", PKT_W'(sched_busy), '0);
        checkOutput("rstmid_tx_start", PKT_W'(bus.tx_start), '0);
        checkOutput("rstmid_done", PKT_W'(bus.done), '0);
        checkOutput("rstmid_err", PKT_W'(bus.err), '0);
        checkOutput("rstmid_frame_cnt", PKT_W'(frame_cnt), '0);
        grant_q.delete();
        active_q.delete();
        bus.req = '0;
        last_end_cycle = -1;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (!bus.tx_busy) seen = 1'b1;
        end
        checkOutput("rstmid_framer_idle", PKT_W'(seen), PKT_W'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req_packet[1*PKT_W +: PKT_W] = makePkt(1, 4'd0);
        bus.req_packet[3*PKT_W +: PKT_W] = makePkt(3, 4'd0);
        pushExp(1, 4'd0, 1'b0);
        pushExp(3, 4'd0, 1'b0);
        bus.req = 4'b1010;
        waitIdle("post_rst_idle", 400);
        checkOutput("post_rst_frame_cnt", PKT_W'(frame_cnt), PKT_W'(2));

        // Saturation of the frame counter.
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        checkOutput("sat_preload", PKT_W'(frame_cnt), PKT_W'(16'hFFFE));
        bus.req_packet[0 +: PKT_W] = makePkt(0, 4'd0);
        for (int r = 0; r < 2; r++) begin
            pushExp(0, 4'd0, 1'b0);
            bus.req = 4'b0001;
            waitIdle($sformatf("sat%0d_idle", r), 200);
            checkOutput($sformatf("sat%0d_frame_cnt", r), PKT_W'(frame_cnt), PKT_W'(16'hFFFF));
        end

        checkOutput("grant_q_empty", PKT_W'(grant_q.size()), '0);
        checkOutput("active_q_empty", PKT_W'(active_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
